// File: rtl/escaneo_pkg.sv
// Shared types and helpers for the BCD display scanner: FSM states, dash
// code, decimal range limit and the double-dabble nibble adjustment.
package escaneo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  localparam logic [3:0] DASH_CODE = 4'hF;

  // Largest value that fits in n decimal digits (10^n - 1).
  function automatic int unsigned max_val(input int unsigned n);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < n; i++) v = v * 10;
    return v - 1;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/escaneo_digitos_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per cycle,
// DATA_W steps, then a one-cycle COMMIT strobe with the result.
module bin2bcd_seq
  import escaneo_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    load,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    ovf_out,
  output logic                    commit
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned MAX_V = max_val(NUM_DIGITS);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shift_q;
  logic [BCD_W-1:0]   scratch_q;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic               ovf_pend_q;
  logic               last_step;

  assign last_step = (bit_cnt_q == CNT_W'(DATA_W - 1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = CONV;
      CONV:    if (last_step) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    commit = (state_q == COMMIT);
  end

  always_comb begin
    adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) adj[4*i +: 4] = add3(scratch_q[4*i +: 4]);
  end

  // Carry out of the top nibble falls off the left end of the combined shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      bit_cnt_q  <= '0;
      ovf_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (load) begin
          shift_q    <= data_in;
          scratch_q  <= '0;
          bit_cnt_q  <= '0;
          ovf_pend_q <= (32'(data_in) > MAX_V);
        end
        CONV: begin
          {scratch_q, shift_q} <= {adj, shift_q} << 1;
          bit_cnt_q            <= bit_cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bcd_out = scratch_q;
  assign ovf_out = ovf_pend_q;

endmodule

// File: rtl/escaneo_digitos.sv
// Binary-to-BCD display front end: holds the committed digits and scans them
// one per SCAN_DIV cycles. Optional leading-zero blanking: ESCANEO_BLANK_CEROS_EN.
module escaneo_digitos
  import escaneo_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [7:0]            digito_out,
  output logic [NUM_DIGITS-1:0] anodo_out
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [BCD_W-1:0]      bcd;
  logic                  conv_ovf;
  logic                  commit;
  logic [BCD_W-1:0]      display_q, display_d;
  logic [SCAN_W-1:0]     scan_cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_DIGITS-1:0] blank;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .DATA_W     (DATA_W)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .load    (load),
    .busy    (busy),
    .bcd_out (bcd),
    .ovf_out (conv_ovf),
    .commit  (commit)
  );

  // Output registers read the post-commit value so new digits appear right
  // after COMMIT rather than one cycle later.
  always_comb begin
    display_d = display_q;
    if (commit) display_d = conv_ovf ? {NUM_DIGITS{DASH_CODE}} : bcd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      display_q <= '0;
      overflow  <= 1'b0;
    end else begin
      display_q <= display_d;
      if (commit) overflow <= conv_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_q <= '0;
      idx_q      <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
    end
  end

`ifdef ESCANEO_BLANK_CEROS_EN
  // Digit i is blank when it and every digit above it are zero; digit 0 never
  // blanks, and dash nibbles are nonzero so overflow is never blanked.
  logic nz_seen;
  always_comb begin
    blank   = '0;
    nz_seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (display_d[4*i +: 4] != 4'h0) nz_seen = 1'b1;
      blank[i] = ~nz_seen;
    end
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      digito_out <= 8'h00;
      anodo_out  <= '1;
    end else begin
      digito_out <= {4'h0, display_d[4*idx_q +: 4]};
      anodo_out  <= blank[idx_q] ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    end
  end

endmodule

// File: tb/tb_escaneo_digitos.sv
// Directed bench for escaneo_digitos: scan order, conversions, overflow,
// ignored loads, mid-conversion reset and optional zero blanking.
module tb_escaneo_digitos;

  logic        clk;
  logic        rst;
  logic [13:0] data_in;
  logic        load;
  logic        busy;
  logic        overflow;
  logic [7:0]  digito_out;
  logic [3:0]  anodo_out;

  typedef struct {
    logic [7:0] dig;
    logic [3:0] an;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  escaneo_digitos #(
    .NUM_DIGITS (4),
    .DATA_W     (14),
    .SCAN_DIV   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .busy       (busy),
    .overflow   (overflow),
    .digito_out (digito_out),
    .anodo_out  (anodo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected anode pattern for a slot given the displayed BCD digits.
  function automatic logic [3:0] exp_an(input int s, input logic [15:0] d);
    logic [3:0] a;
    a    = 4'b1111;
    a[s] = 1'b0;
`ifdef ESCANEO_BLANK_CEROS_EN
    if (s > 0 && (d >> (4 * s)) == 16'h0) a = 4'b1111;
`endif
    return a;
  endfunction

  task automatic do_load(input logic [13:0] v);
    data_in = v;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  // Pushes the expected slot values, aligns to the start of slot 0, then
  // pops and compares one sample per slot.
  task automatic scan_check(input string tag, input logic [15:0] d);
    logic [3:0] prev;
    logic       found;
    exp_t       e;
    for (int s = 0; s < 4; s++) sb.push_back('{dig: {4'h0, d[4*s +: 4]}, an: exp_an(s, d)});
    prev  = anodo_out;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (prev != 4'b1110 && anodo_out == 4'b1110) found = 1'b1;
      else prev = anodo_out;
    end
    check({tag, "_sync"}, 32'(found), 32'd1);
    for (int s = 0; s < 4; s++) begin
      e = sb.pop_front();
      if (s > 0) repeat (4) @(negedge clk);
      check($sformatf("%s_dig%0d", tag, s), 32'(digito_out), 32'(e.dig));
      check($sformatf("%s_an%0d", tag, s), 32'(anodo_out), 32'(e.an));
    end
  endtask

  initial begin
    int   n;
    exp_t e;
    rst     = 1'b1;
    load    = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_dig", 32'(digito_out), 32'h00);
    check("rst_an", 32'(anodo_out), 32'hF);

    // Free-running scan of an all-zero display, every cycle for 16 cycles.
    rst = 1'b0;
    for (int c = 0; c < 16; c++) sb.push_back('{dig: 8'h00, an: exp_an(c / 4, 16'h0000)});
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("scan_an_c%0d", c), 32'(anodo_out), 32'(e.an));
      check($sformatf("scan_dig_c%0d", c), 32'(digito_out), 32'(e.dig));
      check($sformatf("scan_busy_c%0d", c), 32'(busy), 32'd0);
    end

    do_load(14'd1234);
    wait_idle("busy_1234", n);
    check("busy_len_1234", 32'(n), 32'd15);
    check("ovf_1234", 32'(overflow), 32'd0);
    scan_check("v1234", 16'h1234);

    do_load(14'd10000);
    wait_idle("busy_10000", n);
    check("ovf_10000", 32'(overflow), 32'd1);
    scan_check("v10000", 16'hFFFF);

    do_load(14'd9999);
    wait_idle("busy_9999", n);
    check("ovf_9999", 32'(overflow), 32'd0);
    scan_check("v9999", 16'h9999);

    // A load pulse during a conversion must be dropped.
    do_load(14'd42);
    repeat (3) @(negedge clk);
    check("busy_mid_42", 32'(busy), 32'd1);
    do_load(14'd777);
    wait_idle("busy_42", n);
    repeat (3) @(negedge clk);
    check("busy_after_42", 32'(busy), 32'd0);
    scan_check("v42", 16'h0042);

    // Reset partway through a conversion aborts it and clears the display.
    do_load(14'd5555);
    repeat (7) @(negedge clk);
    check("busy_pre_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_an", 32'(anodo_out), 32'hF);
    check("midrst_dig", 32'(digito_out), 32'h00);
    repeat (20) @(negedge clk);
    check("midrst_idle", 32'(busy), 32'd0);
    scan_check("midrst", 16'h0000);

    do_load(14'd7);
    wait_idle("busy_7", n);
    scan_check("v7", 16'h0007);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
